// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, LSB-first deserialisation,
// optional parity and stop-bit checks around an external 3-tap data sampler.
module uart_rx_ctrl #(
  parameter int unsigned PRESCALE_BITS = 6,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RX_IN,
  input  logic [PRESCALE_BITS-1:0] Prescale,
  input  logic                     PAR_EN,
  input  logic                     PAR_TYP,
  input  logic                     sampled_bit,
  output logic [PRESCALE_BITS-1:0] edge_cnt,
  output logic                     data_samp_en,
  output logic [DATA_WIDTH-1:0]    P_DATA,
  output logic                     data_valid,
  output logic                     par_err,
  output logic                     stp_err
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                   state;
  logic [PRESCALE_BITS-1:0] p_lat;
  logic                     par_en_lat;
  logic                     par_typ_lat;
  logic                     perr;
  logic [DATA_WIDTH-1:0]    shift;
  logic [CNT_W-1:0]         bit_cnt;
  logic                     tick;
  logic                     cfg_ok;
  logic                     exp_par;

  assign cfg_ok       = (Prescale == PRESCALE_BITS'(8))  ||
                        (Prescale == PRESCALE_BITS'(16)) ||
                        (Prescale == PRESCALE_BITS'(32));
  assign tick         = (edge_cnt == p_lat - 1'b1);
  assign data_samp_en = (state != IDLE);
  assign exp_par      = par_typ_lat ? ~^shift : ^shift;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      p_lat       <= '0;
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
      perr        <= 1'b0;
      shift       <= '0;
      bit_cnt     <= '0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      // Entering START leaves edge_cnt at 0, so the first START cycle is phase 0.
      if (state == IDLE || tick) edge_cnt <= '0;
      else                       edge_cnt <= edge_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (!RX_IN && cfg_ok) begin
            p_lat       <= Prescale;
            par_en_lat  <= PAR_EN;
            par_typ_lat <= PAR_TYP;
            perr        <= 1'b0;
            bit_cnt     <= '0;
            state       <= START;
          end
        end
        START: begin
          if (tick) begin
            if (sampled_bit) begin
              state <= IDLE;
            end else begin
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= {sampled_bit, shift[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1))
              state <= par_en_lat ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (tick) begin
            perr  <= (sampled_bit != exp_par);
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            stp_err <= ~sampled_bit;
            par_err <= perr & par_en_lat;
            if (sampled_bit && !(perr && par_en_lat)) begin
              P_DATA     <= shift;
              data_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomised bench for uart_rx_ctrl: drives the serial line, models the 3-tap
// sampler, and predicts each frame's outcome and pulse cycle from frame rules.
module tb_uart_rx_ctrl;

  localparam int PB = 6;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PB-1:0] Prescale;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          sampled_bit = 1'b1;
  logic [PB-1:0] edge_cnt;
  logic          data_samp_en;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  uart_rx_ctrl #(.PRESCALE_BITS(PB), .DATA_WIDTH(DW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .sampled_bit  (sampled_bit),
    .edge_cnt     (edge_cnt),
    .data_samp_en (data_samp_en),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .par_err      (par_err),
    .stp_err      (stp_err)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sampler model: majority of three taps around mid-bit of the current bit.
  int       cur_p = 8;
  logic [1:0] votes = 2'b11;
  always @(posedge CLK) begin
    if (data_samp_en) begin
      if (int'(edge_cnt) == cur_p/2 - 1) votes[0] <= RX_IN;
      if (int'(edge_cnt) == cur_p/2)     votes[1] <= RX_IN;
      if (int'(edge_cnt) == cur_p/2 + 1)
        sampled_bit <= (votes[0] & votes[1]) | (votes[0] & RX_IN) | (votes[1] & RX_IN);
    end
  end

  typedef struct {
    int unsigned   cyc;
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           mon_e;
  logic [DW-1:0] last_good = '0;
  int unsigned   last_end  = 0;

  always @(negedge CLK) begin
    if (RST === 1'b1 && (data_valid || par_err || stp_err)) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("data_valid", {31'd0, data_valid}, {31'd0, mon_e.dv});
        check("par_err", {31'd0, par_err}, {31'd0, mon_e.pe});
        check("stp_err", {31'd0, stp_err}, {31'd0, mon_e.se});
        check("p_data", {24'd0, P_DATA}, {24'd0, mon_e.data});
      end
    end
  end

  // Called at a negedge. abort_at = line bit index at which reset is asserted mid-bit.
  task automatic send_frame(input int p, input logic [DW-1:0] data, input logic pe,
                            input logic pt, input logic par_ok, input logic stop_bit,
                            input int abort_at, input logic scramble);
    logic [DW+2:0] bits;
    int            n;
    logic          pbit;
    int unsigned   start;
    ev_t           e;
    pbit = pt ? ~^data : ^data;
    if (!par_ok) pbit = ~pbit;
    bits = '0;
    for (int i = 0; i < DW; i++) bits[i+1] = data[i];
    n = DW + 1;
    if (pe) begin
      bits[n] = pbit;
      n++;
    end
    bits[n] = stop_bit;
    n++;
    Prescale = PB'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    cur_p    = p;
    start    = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
    e.cyc    = start + p * n;
    e.pe     = pe && !par_ok;
    e.se     = !stop_bit;
    e.dv     = !e.pe && !e.se;
    e.data   = e.dv ? data : last_good;
    exp_q.push_back(e);
    for (int b = 0; b < n; b++) begin
      RX_IN = bits[b];
      if (b == abort_at) begin
        repeat (p/2) @(negedge CLK);
        RST = 1'b0;
        void'(exp_q.pop_back());
        return;
      end
      if (b == 1 && scramble) begin
        Prescale = PB'($urandom);
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
      end
      repeat (p) @(negedge CLK);
    end
    RX_IN = 1'b1;
    if (e.dv) last_good = data;
    last_end = e.cyc;
  endtask

  task automatic check_quiet(input string tag);
    #1;
    check({tag, "_edge_cnt"}, {26'd0, edge_cnt}, 32'd0);
    check({tag, "_samp_en"}, {31'd0, data_samp_en}, 32'd0);
    check({tag, "_pulses"}, {29'd0, data_valid, par_err, stp_err}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d;
    int          p;
    RST = 1'b0; RX_IN = 1'b1; Prescale = PB'(8); PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    check_quiet("reset");
    check("reset_p_data", {24'd0, P_DATA}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    last_end = cyc;

    send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    repeat (3) @(negedge CLK);

    send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    repeat (3) @(negedge CLK);
    send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    repeat (3) @(negedge CLK);

    send_frame(32, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    repeat (3) @(negedge CLK);

    // Start-bit glitch: START spans cycles d+1..d+16, back in IDLE at d+17.
    Prescale = PB'(16); PAR_EN = 1'b0; cur_p = 16;
    d = cyc;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (13) @(negedge CLK);
    check("glitch_tick_edge_cnt", {26'd0, edge_cnt}, 32'd15);
    check("glitch_tick_samp_en", {31'd0, data_samp_en}, 32'd1);
    @(negedge CLK);
    check_quiet("glitch_idle");
    last_end = d + 17;
    repeat (3) @(negedge CLK);

    send_frame(8, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    repeat (3) @(negedge CLK);

    send_frame(16, 8'h96, 1'b0, 1'b0, 1'b1, 1'b1, 5, 1'b0);
    check_quiet("abort");
    check("abort_p_data", {24'd0, P_DATA}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    last_good = '0;
    Prescale = PB'(4); RX_IN = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      check("bad_prescale_samp_en", {31'd0, data_samp_en}, 32'd0);
    end
    RX_IN = 1'b1;
    @(negedge CLK);
    last_end = cyc;

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      send_frame(p, 8'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) != 0), -1, 1'b1);
      repeat ($urandom_range(1, 4)) @(negedge CLK);
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK);
    check("pending_frames", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
